frogger_game_ctrl: RTL and testbench

//  Parametrised game-flow controller for the Frogger top level. It owns level, lives and

---
 rtl/frogger_game_ctrl_if.sv | 38 +++
 rtl/frogger_game_ctrl.sv | 152 +++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frogger_game_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frogger_game_ctrl_if : game-flow controller signal bundle                   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
interface frogger_game_ctrl_if #(
  parameter int LEVEL_W   = 4,
  parameter int NUM_LANES = 8,
  parameter int SPEED_W   = 4,
  parameter int TIMER_W   = 11
);
  logic                         frame_tick_i;
  logic                         death_collision_i;
  logic                         win_collision_i;
  logic                         restart_req_i;
  logic [NUM_LANES*SPEED_W-1:0] base_speed_i;
  logic [LEVEL_W-1:0]           current_level_o;
  logic [2:0]                   lives_o;
  logic [NUM_LANES*SPEED_W-1:0] lane_speed_o;
  logic                         round_reset_o;
  logic                         game_over_o;
  logic [1:0]                   state_o;
  logic [TIMER_W-1:0]           time_left_o;

  // The controller is the master; collision/frog/car/display logic is the slave.
  modport master (
    input  frame_tick_i, death_collision_i, win_collision_i, restart_req_i, base_speed_i,
    output current_level_o, lives_o, lane_speed_o, round_reset_o, game_over_o, state_o,
           time_left_o
  );

  modport slave (
    output frame_tick_i, death_collision_i, win_collision_i, restart_req_i, base_speed_i,
    input  current_level_o, lives_o, lane_speed_o, round_reset_o, game_over_o, state_o,
           time_left_o
  );
endinterface
`default_nettype wire

// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frogger_game_ctrl : level/lives/round sequencing for the Frogger top level  |
// | Optional round timer enabled by defining FROGGER_TIMER_EN.                  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module frogger_game_ctrl #(
  parameter int NUM_LEVELS   = 10,
  parameter int LEVEL_W      = 4,
  parameter int NUM_LIVES    = 3,
  parameter int NUM_LANES    = 8,
  parameter int SPEED_W      = 4,
  parameter int HOLD_FRAMES  = 30,
  parameter int ROUND_FRAMES = 1800,
  parameter int TIMER_W      = 11
) (
  input wire                  clk,
  input wire                  reset,
  frogger_game_ctrl_if.master bus
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);
  localparam int SUM_W = SPEED_W + LEVEL_W;
  localparam logic [SUM_W-1:0] SPEED_MAX = SUM_W'((1 << SPEED_W) - 1);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_DYING     = 2'd1,
    ST_LEVEL_UP  = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [LEVEL_W-1:0]           level_q, level_d;
  logic [2:0]                   lives_q, lives_d;
  logic [HOLD_W-1:0]            hold_q, hold_d;
  logic                         round_reset_q, round_reset_d;
  logic                         game_over_q, game_over_d;
  logic                         win_q;
  logic                         win_edge_w;
  logic                         timeout_w;
  logic [NUM_LANES*SPEED_W-1:0] lane_speed_d, lane_speed_q;

  assign win_edge_w = bus.win_collision_i & ~win_q;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    if (bus.restart_req_i) begin
      state_d = ST_PLAY;
      level_d = '0;
      lives_d = 3'(NUM_LIVES);
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (bus.death_collision_i || timeout_w) begin
            state_d = ST_DYING;
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end else if (win_edge_w) begin
            state_d = ST_LEVEL_UP;
            level_d = (level_q == LEVEL_LAST) ? '0 : level_q + LEVEL_W'(1);
          end
        end
        ST_DYING, ST_LEVEL_UP: begin
          if (bus.frame_tick_i) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              state_d = (state_q == ST_DYING && lives_q == 3'd0) ? ST_GAME_OVER : ST_PLAY;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    // A restart from PLAY still produces a one-cycle round_reset pulse.
    round_reset_d = bus.restart_req_i | (state_d != ST_PLAY);
    game_over_d   = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_PLAY;
      level_q       <= '0;
      lives_q       <= 3'(NUM_LIVES);
      hold_q        <= '0;
      round_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      hold_q        <= hold_d;
      round_reset_q <= round_reset_d;
      game_over_q   <= game_over_d;
      win_q         <= bus.win_collision_i;
    end
  end

`ifdef FROGGER_TIMER_EN
  logic [TIMER_W-1:0] time_left_q;
  logic               reload_w;

  assign reload_w  = bus.restart_req_i | (state_q != ST_PLAY && state_d == ST_PLAY);
  assign timeout_w = (state_q == ST_PLAY) && bus.frame_tick_i && (time_left_q == TIMER_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_left_q <= TIMER_W'(ROUND_FRAMES);
    end else if (reload_w) begin
      time_left_q <= TIMER_W'(ROUND_FRAMES);
    end else if (state_q == ST_PLAY && bus.frame_tick_i && time_left_q != '0) begin
      time_left_q <= time_left_q - TIMER_W'(1);
    end
  end

  assign bus.time_left_o = time_left_q;
`else
  assign timeout_w       = 1'b0;
  assign bus.time_left_o = '0;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [SUM_W-1:0] sum_w;
    assign sum_w = {{LEVEL_W{1'b0}}, bus.base_speed_i[i*SPEED_W +: SPEED_W]}
                 + {{SPEED_W{1'b0}}, level_q};
    assign lane_speed_d[i*SPEED_W +: SPEED_W] =
      (sum_w > SPEED_MAX) ? SPEED_MAX[SPEED_W-1:0] : sum_w[SPEED_W-1:0];
  end

  // Not reset: it tracks base_speed at level 0 on any clock while reset is held,
  // which avoids an asynchronous load of a data-dependent value.
  always_ff @(posedge clk) begin
    lane_speed_q <= lane_speed_d;
  end

  assign bus.current_level_o = level_q;
  assign bus.lives_o         = lives_q;
  assign bus.lane_speed_o    = lane_speed_q;
  assign bus.round_reset_o   = round_reset_q;
  assign bus.game_over_o     = game_over_q;
  assign bus.state_o         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frogger_game_ctrl : directed + random bench with a behavioural model     |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_frogger_game_ctrl;

  localparam int NUM_LEVELS = 10;
  localparam int LEVEL_W    = 4;
  localparam int NUM_LIVES  = 3;
  localparam int NUM_LANES  = 8;
  localparam int SPEED_W    = 4;
  localparam int HOLD       = 30;
  localparam int RF         = 4;
  localparam int TIMER_W    = 11;
  localparam int SMAX       = (1 << SPEED_W) - 1;
`ifdef FROGGER_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frogger_game_ctrl_if #(.LEVEL_W(LEVEL_W), .NUM_LANES(NUM_LANES),
                         .SPEED_W(SPEED_W), .TIMER_W(TIMER_W)) bus ();

  frogger_game_ctrl #(
    .NUM_LEVELS(NUM_LEVELS), .LEVEL_W(LEVEL_W), .NUM_LIVES(NUM_LIVES),
    .NUM_LANES(NUM_LANES), .SPEED_W(SPEED_W), .HOLD_FRAMES(HOLD),
    .ROUND_FRAMES(RF), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: game state as plain integers.
  int m_state, m_level, m_lives, m_hold, m_time;
  bit m_win_prev, m_rr, m_go;
  logic [NUM_LANES*SPEED_W-1:0] m_speed;

  function automatic logic [NUM_LANES*SPEED_W-1:0] scaled(
      input logic [NUM_LANES*SPEED_W-1:0] base, input int lvl);
    logic [NUM_LANES*SPEED_W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      s = int'(base[i*SPEED_W +: SPEED_W]) + lvl;
      r[i*SPEED_W +: SPEED_W] = SPEED_W'((s > SMAX) ? SMAX : s);
    end
    return r;
  endfunction

  function automatic int round_len();
    return TIMER_ON ? RF : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_lives = NUM_LIVES; m_hold = 0;
    m_time = round_len(); m_win_prev = 1'b0; m_rr = 1'b0; m_go = 1'b0;
  endtask

  task automatic model_step(input bit tick, input bit death, input bit win, input bit restart);
    bit win_edge, timeout;
    m_speed    = scaled(bus.base_speed_i, m_level);
    win_edge   = win && !m_win_prev;
    m_win_prev = win;
    timeout    = TIMER_ON && m_state == 0 && tick && m_time == 1;
    if (TIMER_ON && m_state == 0 && tick && m_time > 0) m_time = m_time - 1;
    if (restart) begin
      m_state = 0; m_level = 0; m_lives = NUM_LIVES; m_hold = 0; m_time = round_len();
    end else if (m_state == 0) begin
      if (death || timeout) begin
        m_state = 1;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      end else if (win_edge) begin
        m_state = 2;
        m_level = (m_level + 1) % NUM_LEVELS;
      end
    end else if (m_state != 3 && tick) begin
      m_hold = m_hold + 1;
      if (m_hold == HOLD) begin
        m_hold = 0;
        if (m_state == 1 && m_lives == 0) m_state = 3;
        else begin
          m_state = 0;
          m_time  = round_len();
        end
      end
    end
    m_rr = restart || m_state != 0;
    m_go = m_state == 3;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_core(input string tag);
    chk({tag, ".state"}, 64'(bus.state_o), 64'(m_state));
    chk({tag, ".level"}, 64'(bus.current_level_o), 64'(m_level));
    chk({tag, ".lives"}, 64'(bus.lives_o), 64'(m_lives));
    chk({tag, ".round_reset"}, 64'(bus.round_reset_o), 64'(m_rr));
    chk({tag, ".game_over"}, 64'(bus.game_over_o), 64'(m_go));
    chk({tag, ".time_left"}, 64'(bus.time_left_o), 64'(m_time));
  endtask

  task automatic check_all(input string tag);
    check_core(tag);
    chk({tag, ".lane_speed"}, 64'(bus.lane_speed_o), 64'(m_speed));
  endtask

  task automatic cycle(input string tag, input bit tick, input bit death, input bit win,
                       input bit restart);
    bus.frame_tick_i      = tick;
    bus.death_collision_i = death;
    bus.win_collision_i   = win;
    bus.restart_req_i     = restart;
    @(posedge clk);
    model_step(tick, death, win, restart);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic win_round(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(tag, HOLD);
  endtask

  task automatic death_round(input string tag);
    cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(tag, HOLD);
  endtask

  task automatic async_reset(input string tag);
    bus.frame_tick_i = 1'b0; bus.death_collision_i = 1'b0;
    bus.win_collision_i = 1'b0; bus.restart_req_i = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_core(tag);
    @(posedge clk);
    #1;
    m_speed = scaled(bus.base_speed_i, 0);
    chk({tag, ".lane_speed"}, 64'(bus.lane_speed_o), 64'(m_speed));
    reset = 1'b0;
  endtask

  initial begin
    bus.frame_tick_i      = 1'b0;
    bus.death_collision_i = 1'b0;
    bus.win_collision_i   = 1'b0;
    bus.restart_req_i     = 1'b0;
    bus.base_speed_i      = 32'h3172_905E;

    // Reset and first cycle after release.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    m_speed = scaled(bus.base_speed_i, 0);
    reset = 1'b0;
    check_all("reset");
    cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_lives", 64'(bus.lives_o), 64'd3);
    chk("reset_speed_eq_base", 64'(bus.lane_speed_o), 64'h3172_905E);

    // Held goal counts once.
    repeat (5) cycle("win_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("win_hold_level", 64'(bus.current_level_o), 64'd1);
    chk("win_hold_state", 64'(bus.state_o), 64'd2);
    chk("win_hold_rr", 64'(bus.round_reset_o), 64'd1);
    ticks("lvlup_hold", HOLD);
    chk("lvlup_exit_state", 64'(bus.state_o), 64'd0);
    chk("lvlup_exit_rr", 64'(bus.round_reset_o), 64'd0);
    chk("lane0_lvl1", 64'(bus.lane_speed_o[3:0]), 64'd15);

    // Saturation and level wrap.
    win_round("lvl2");
    chk("lane0_lvl2_sat", 64'(bus.lane_speed_o[3:0]), 64'd15);
    repeat (7) win_round("climb");
    chk("level9", 64'(bus.current_level_o), 64'd9);
    cycle("wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("level_wrap", 64'(bus.current_level_o), 64'd0);
    ticks("wrap_hold", HOLD);

    // Lives run out, game over freezes, restart recovers.
    death_round("death1");
    chk("lives_after_1", 64'(bus.lives_o), 64'd2);
    death_round("death2");
    chk("lives_after_2", 64'(bus.lives_o), 64'd1);
    death_round("death3");
    chk("gameover_state", 64'(bus.state_o), 64'd3);
    chk("gameover_flag", 64'(bus.game_over_o), 64'd1);
    cycle("go_coll", 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("go_coll", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("go_coll", 1'b1, 1'b1, 1'b1, 1'b0);
    ticks("go_ticks", 40);
    chk("go_frozen_lives", 64'(bus.lives_o), 64'd0);
    chk("go_frozen_state", 64'(bus.state_o), 64'd3);
    cycle("restart", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_state", 64'(bus.state_o), 64'd0);
    chk("restart_lives", 64'(bus.lives_o), 64'd3);
    chk("restart_rr_pulse", 64'(bus.round_reset_o), 64'd1);
    cycle("after_restart", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_rr_low", 64'(bus.round_reset_o), 64'd0);

    // Death beats win in the same cycle; async reset mid-hold.
    repeat (4) win_round("to_lvl4");
    cycle("death_win", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("dw_state", 64'(bus.state_o), 64'd1);
    chk("dw_lives", 64'(bus.lives_o), 64'd2);
    chk("dw_level", 64'(bus.current_level_o), 64'd4);
    ticks("dying_part", 10);
    async_reset("areset");
    chk("areset_level", 64'(bus.current_level_o), 64'd0);
    cycle("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Round timer.
    ticks("timer", RF);
`ifdef FROGGER_TIMER_EN
    chk("timeout_state", 64'(bus.state_o), 64'd1);
    chk("timeout_lives", 64'(bus.lives_o), 64'd2);
`else
    chk("no_timer_time", 64'(bus.time_left_o), 64'd0);
    chk("no_timer_state", 64'(bus.state_o), 64'd0);
    chk("no_timer_lives", 64'(bus.lives_o), 64'd3);
`endif
    cycle("restart2", 1'b0, 1'b0, 1'b0, 1'b1);

    // Random play against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) bus.base_speed_i = $urandom;
      cycle("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 23) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 120) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
